// File: rtl/axi_read_responder_if.sv
// AR/R channel bundle for the read responder; slave is the responder side.
interface axi_read_responder_if #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64
);
   logic                  arvalid_i;
   logic [ADDR_WIDTH-1:0] araddr_i;
   logic [1:0]            arburst_i;
   logic [7:0]            arlen_i;
   logic [2:0]            arsize_i;
   logic                  arready_o;
   logic                  rvalid_o;
   logic [DATA_WIDTH-1:0] rdata_o;
   logic [1:0]            rresp_o;
   logic                  rlast_o;
   logic                  rready_i;

   modport slave (
      input  arvalid_i, araddr_i, arburst_i, arlen_i, arsize_i, rready_i,
      output arready_o, rvalid_o, rdata_o, rresp_o, rlast_o
   );

   modport master (
      output arvalid_i, araddr_i, arburst_i, arlen_i, arsize_i, rready_i,
      input  arready_o, rvalid_o, rdata_o, rresp_o, rlast_o
   );
endinterface

// File: rtl/axi_read_responder.sv
// Single-outstanding AXI read responder over a backdoor-loaded word memory.
// Per-beat legality check returns SLVERR/zero data for unsupported or out-of-range beats.
module axi_read_responder #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned MEM_DEPTH  = 1024
) (
   input  logic                         clk_a,
   input  logic                         resetn_a,
   axi_read_responder_if.slave          s_axi,
   input  logic                         wr_en_i,
   input  logic [$clog2(MEM_DEPTH)-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0]        wr_data_i
);
   localparam int unsigned IDX_W  = ADDR_WIDTH - 3;
   localparam int unsigned MEM_AW = $clog2(MEM_DEPTH);
   localparam logic [1:0]  RESP_OKAY   = 2'd0;
   localparam logic [1:0]  RESP_SLVERR = 2'd2;
   localparam logic [1:0]  BURST_FIXED = 2'd0;
   localparam logic [1:0]  BURST_INCR  = 2'd1;
   localparam logic [2:0]  SIZE_8B     = 3'd3;

   typedef enum logic {IDLE, BURST} state_t;

   state_t                r_state;
   logic [IDX_W-1:0]      r_idx;
   logic [1:0]            r_burst;
   logic [2:0]            r_size;
   logic [7:0]            r_len;
   logic [7:0]            r_cnt;
   logic                  r_arready;
   logic                  r_rvalid;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_rresp;
   logic                  r_rlast;
   logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

   logic                  w_ar_hs;
   logic                  w_beat_done;
   logic [IDX_W-1:0]      w_next_idx;
   logic [IDX_W-1:0]      w_fetch_idx;
   logic [1:0]            w_fetch_burst;
   logic [2:0]            w_fetch_size;
   logic                  w_fetch_ok;
   logic [DATA_WIDTH-1:0] w_fetch_data;
   logic                  w_unused_lsbs;

   assign s_axi.arready_o = r_arready;
   assign s_axi.rvalid_o  = r_rvalid;
   assign s_axi.rdata_o   = r_rdata;
   assign s_axi.rresp_o   = r_rresp;
   assign s_axi.rlast_o   = r_rlast;

   // Byte offset within a beat is dropped: addresses align down to the word.
   assign w_unused_lsbs = ^s_axi.araddr_i[2:0];

   // Backdoor port; no reset so contents survive resetn_a.
   always_ff @(posedge clk_a) begin
      if (wr_en_i) r_mem[wr_addr_i] <= wr_data_i;
   end

   // Word to fetch this edge: the new burst's first word or the following beat's word.
   always_comb begin
      w_ar_hs       = (r_state == IDLE) && r_arready && s_axi.arvalid_i;
      w_beat_done   = r_rvalid && s_axi.rready_i;
      w_next_idx    = (r_burst == BURST_INCR) ? r_idx + IDX_W'(1) : r_idx;
      w_fetch_idx   = w_ar_hs ? s_axi.araddr_i[ADDR_WIDTH-1:3] : w_next_idx;
      w_fetch_burst = w_ar_hs ? s_axi.arburst_i : r_burst;
      w_fetch_size  = w_ar_hs ? s_axi.arsize_i  : r_size;
      w_fetch_ok    = ((w_fetch_burst == BURST_FIXED) || (w_fetch_burst == BURST_INCR)) &&
                      (w_fetch_size == SIZE_8B) &&
                      (w_fetch_idx < IDX_W'(MEM_DEPTH));
      w_fetch_data  = '0;
      if (w_fetch_ok) w_fetch_data = r_mem[w_fetch_idx[MEM_AW-1:0]];
   end

   always_ff @(posedge clk_a or negedge resetn_a) begin
      if (!resetn_a) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_burst   <= '0;
         r_size    <= '0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
         r_rlast   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_arready <= 1'b1;
               if (w_ar_hs) begin
                  r_state   <= BURST;
                  r_arready <= 1'b0;
                  r_idx     <= w_fetch_idx;
                  r_burst   <= s_axi.arburst_i;
                  r_size    <= s_axi.arsize_i;
                  r_len     <= s_axi.arlen_i;
                  r_cnt     <= '0;
                  r_rvalid  <= 1'b1;
                  r_rdata   <= w_fetch_data;
                  r_rresp   <= w_fetch_ok ? RESP_OKAY : RESP_SLVERR;
                  r_rlast   <= (s_axi.arlen_i == 8'd0);
               end
            end
            BURST: begin
               if (w_beat_done) begin
                  if (r_rlast) begin
                     r_state   <= IDLE;
                     r_arready <= 1'b1;
                     r_rvalid  <= 1'b0;
                     r_rdata   <= '0;
                     r_rresp   <= RESP_OKAY;
                     r_rlast   <= 1'b0;
                  end else begin
                     r_cnt   <= r_cnt + 8'd1;
                     r_idx   <= w_next_idx;
                     r_rdata <= w_fetch_data;
                     r_rresp <= w_fetch_ok ? RESP_OKAY : RESP_SLVERR;
                     r_rlast <= ((r_cnt + 8'd1) == r_len);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/axi_read_responder.md
AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

Interface
REQ-001 The block SHALL have a single clock clk_a, and reset resetn_a SHALL be asynchronous and active-low.
REQ-002 The block SHALL provide these parameters (name, default, meaning):
- ADDR_WIDTH, 64, AR address width.
- DATA_WIDTH, 64, R data width; fixed 8-byte beats.
- MEM_DEPTH, 1024, number of DATA_WIDTH words held.
REQ-003 The block SHALL provide these ports (name, direction, width, meaning):
- clk_a, in, 1, clock.
- resetn_a, in, 1, async active-low reset.
- arvalid_i, in, 1, read address valid.
- araddr_i, in, ADDR_WIDTH, byte address.
- arburst_i, in, 2, 0=FIXED, 1=INCR, 2/3=unsupported.
- arlen_i, in, 8, beats minus 1.
- arsize_i, in, 3, beat size; only 3 supported.
- arready_o, out, 1, address accepted.
- rvalid_o, out, 1, read data valid.
- rdata_o, out, DATA_WIDTH, read data.
- rresp_o, out, 2, 0=OKAY, 2=SLVERR.
- rlast_o, out, 1, final beat of burst.
- rready_i, in, 1, master accepts beat.
- wr_en_i, in, 1, backdoor memory write enable.
- wr_addr_i, in, clog2(MEM_DEPTH), backdoor word index.
- wr_data_i, in, DATA_WIDTH, backdoor write data.

Function
REQ-004 The block SHALL implement a state machine with states IDLE and BURST, with one outstanding burst at most.
REQ-005 arready_o SHALL be 1 only in IDLE; the AR handshake SHALL occur when arvalid_i && arready_o.
REQ-006 On the handshake, the block SHALL capture araddr_i, arburst_i, arlen_i and arsize_i, and SHALL enter BURST on the next edge.
REQ-007 Beat 0 SHALL be presented (rvalid_o=1) on the first cycle after the handshake, giving a latency of 1 cycle.
REQ-008 A beat SHALL complete when rvalid_o && rready_i; the next beat SHALL be presented in the following cycle, with no bubble.
REQ-009 While rvalid_o && !rready_i, rdata_o, rresp_o and rlast_o SHALL be held stable.
REQ-010 rlast_o SHALL be 1 exactly on beat arlen (the beat counter is 8 bits; arlen=0 gives a single beat with rlast_o=1).
REQ-011 On completion of the last beat, the block SHALL return to IDLE, with rvalid_o=0 and arready_o=1 on the next cycle; there SHALL be one idle cycle between bursts.
REQ-012 Word index SHALL be address[ADDR_WIDTH-1:3]; the low 3 bits SHALL be ignored, aligning the address down.
REQ-013 Address stepping SHALL depend on the burst type:
- INCR: the address SHALL advance +8 per completed beat, modulo 2^ADDR_WIDTH.
- FIXED: the address SHALL stay constant.
REQ-014 A beat SHALL return rresp_o=OKAY and mem[word index] only when all of the following hold: arburst is 0 or 1, arsize=3, and word index < MEM_DEPTH.
REQ-015 Any other beat SHALL return rresp_o=SLVERR and rdata_o=0; it SHALL still count toward the burst, and rlast_o SHALL still be generated.
REQ-016 The range check SHALL be made per beat, so an INCR burst crossing MEM_DEPTH gives OKAY beats followed by SLVERR beats.
REQ-017 A backdoor write (wr_en_i=1) SHALL update mem[wr_addr_i] at the clock edge and SHALL be accepted in any state.
REQ-018 If a beat is fetched from the same word in the same cycle as a write to it, that beat SHALL return the pre-write data.
REQ-019 arvalid_i asserted during BURST SHALL be ignored until IDLE; arready_o SHALL stay 0 during BURST.

Reset
REQ-020 While resetn_a=0, the outputs SHALL be arready_o=0, rvalid_o=0, rlast_o=0, rresp_o=0, rdata_o=0, and the state SHALL be IDLE.
REQ-021 On the first edge after resetn_a rises, arready_o SHALL become 1.
REQ-022 Reset asserted mid-burst SHALL abort the burst immediately, asynchronously; no further beats of that burst SHALL be issued.
REQ-023 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-024 Backdoor load of words 0..31 with value = index, followed by INCR read addr 0x0 with arlen=31 and rready=1 -> 32 beats with data 0..31, all OKAY, rlast only on beat 31, and arready=1 one cycle after the last beat.
REQ-025 Same burst with rready toggled 1,0,0,1 repeatedly -> data/resp/last held during stalls, with no beat lost or duplicated.
REQ-026 INCR read addr (MEM_DEPTH-2)*8 with arlen=3 -> beats 0-1 OKAY with memory data, beats 2-3 SLVERR with data 0, and rlast on beat 3.
REQ-027 FIXED read addr 0x28 with arlen=3, and arsize=2 read arlen=0 -> four beats of mem[5] OKAY; the arsize=2 read gives a single SLVERR beat with rlast=1.
REQ-028 resetn_a pulsed low during beat 10 of a 32-beat burst -> rvalid=0 immediately, arready=1 on the first edge after release, and a new burst is served correctly.
